// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder.
//   MASK_*      : access size encodings carried on dmem_maskMode
//   COUNT_WIDTH : width of the saturating read/write counters
package dmem_pkg;

  localparam logic [1:0] MASK_B   = 2'd0;
  localparam logic [1:0] MASK_H   = 2'd1;
  localparam logic [1:0] MASK_W   = 2'd2;
  localparam logic [1:0] MASK_RSV = 2'd3;

  localparam int COUNT_WIDTH = 16;

endpackage

// File: rtl/dmem_load_fmt.sv
// Load formatter: picks the addressed byte/half out of a 32-bit word and
// right-aligns it with sign or zero extension.
//   i_word : full array word
//   i_lane : byte lane within the word (already known to be aligned)
//   i_mask : access size (byte / half / word)
//   i_sext : sign-extend sub-word loads
//   o_data : right-aligned load data (0 for the reserved size)
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_mask,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_lane +: 8];
  // Half-word lanes are {lane[1],1}:{lane[1],0}, i.e. upper or lower half.
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = 32'h0;
    case (i_mask)
      MASK_B:  o_data = {{24{i_sext & w_byte[7]}}, w_byte};
      MASK_H:  o_data = {{16{i_sext & w_half[15]}}, w_half};
      MASK_W:  o_data = i_word;
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-cycle data-memory responder with access checking and statistics.
//   clk, reset          : clock, synchronous active-high reset (status only)
//   dmem_addr           : byte address of the access
//   dmem_valid          : request valid
//   dmem_memRead/Write  : read / write request (both may be set together)
//   dmem_maskMode       : 0 byte, 1 half, 2 word, 3 reserved
//   dmem_sext           : sign-extend sub-word loads
//   dmem_writeData      : right-aligned store data
//   dmem_readData       : right-aligned load data, combinational
//   fault_clear         : clears the sticky fault flag
//   fault, fault_addr   : sticky bad-access flag and first offending address
//   rd_cnt, wr_cnt      : saturating counts of good reads / writes
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            dmem_addr,
  input  logic                   dmem_valid,
  input  logic                   dmem_memRead,
  input  logic                   dmem_memWrite,
  input  logic [1:0]             dmem_maskMode,
  input  logic                   dmem_sext,
  input  logic [31:0]            dmem_writeData,
  output logic [31:0]            dmem_readData,
  input  logic                   fault_clear,
  output logic                   fault,
  output logic [31:0]            fault_addr,
  output logic [COUNT_WIDTH-1:0] rd_cnt,
  output logic [COUNT_WIDTH-1:0] wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  logic [31:0]           r_mem [0:DEPTH-1];
  logic                  r_fault;
  logic [31:0]           r_fault_addr;
  logic [COUNT_WIDTH-1:0] r_rd_cnt;
  logic [COUNT_WIDTH-1:0] r_wr_cnt;

  logic [31:0]           w_offset;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic                  w_active;
  logic                  w_oor;
  logic                  w_misalign;
  logic                  w_bad;
  logic                  w_good_rd;
  logic                  w_good_wr;
  logic [31:0]           w_word;
  logic [31:0]           w_fmt;
  logic [3:0]            w_lane_we;
  logic [31:0]           w_wdata;

  assign w_offset = dmem_addr - BASE_ADDR;
  assign w_idx    = w_offset[ADDR_WIDTH+1:2];
  assign w_lane   = w_offset[1:0];
  assign w_active = dmem_valid & (dmem_memRead | dmem_memWrite);

  // Addresses below BASE_ADDR wrap to a huge offset and land here too.
  assign w_oor = |w_offset[31:ADDR_WIDTH+2];

  always_comb begin
    w_misalign = 1'b0;
    case (dmem_maskMode)
      MASK_B:  w_misalign = 1'b0;
      MASK_H:  w_misalign = w_lane[0];
      MASK_W:  w_misalign = (w_lane != 2'd0);
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_bad     = w_active & (w_oor | w_misalign);
  assign w_good_rd = w_active & ~w_bad & dmem_memRead;
  assign w_good_wr = w_active & ~w_bad & dmem_memWrite;

  // Read path: raw array word, formatted, then gated to zero when not a good read.
  assign w_word = r_mem[w_idx];

  dmem_load_fmt u_load_fmt (
    .i_word (w_word),
    .i_lane (w_lane),
    .i_mask (dmem_maskMode),
    .i_sext (dmem_sext),
    .o_data (w_fmt)
  );

  assign dmem_readData = w_good_rd ? w_fmt : 32'h0;

  // Write path: store data is replicated across lanes so each lane enable
  // simply picks up its own byte.
  always_comb begin
    w_lane_we = 4'b0000;
    w_wdata   = dmem_writeData;
    case (dmem_maskMode)
      MASK_B: begin
        w_lane_we = 4'b0001 << w_lane;
        w_wdata   = {4{dmem_writeData[7:0]}};
      end
      MASK_H: begin
        w_lane_we = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{dmem_writeData[15:0]}};
      end
      MASK_W: begin
        w_lane_we = 4'b1111;
        w_wdata   = dmem_writeData;
      end
      default: begin
        w_lane_we = 4'b0000;
        w_wdata   = dmem_writeData;
      end
    endcase
  end

  // Array is never reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && w_good_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_we[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Sticky fault: the address is captured on the first fault, or re-armed
  // when a clear coincides with a new bad access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end else if (w_bad) begin
      r_fault <= 1'b1;
      if (!r_fault || fault_clear) r_fault_addr <= dmem_addr;
    end else if (fault_clear) begin
      r_fault <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_good_rd) r_rd_cnt <= sat_inc(r_rd_cnt);
      if (w_good_wr) r_wr_cnt <= sat_inc(r_wr_cnt);
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
  assign rd_cnt     = r_rd_cnt;
  assign wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  logic        clk;
  logic        reset;
  logic [31:0] dmem_addr;
  logic        dmem_valid;
  logic        dmem_memRead;
  logic        dmem_memWrite;
  logic [1:0]  dmem_maskMode;
  logic        dmem_sext;
  logic [31:0] dmem_writeData;
  logic [31:0] dmem_readData;
  logic        fault_clear;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int n_checks;
  int n_err;

  dmem_resp #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .dmem_addr      (dmem_addr),
    .dmem_valid     (dmem_valid),
    .dmem_memRead   (dmem_memRead),
    .dmem_memWrite  (dmem_memWrite),
    .dmem_maskMode  (dmem_maskMode),
    .dmem_sext      (dmem_sext),
    .dmem_writeData (dmem_writeData),
    .dmem_readData  (dmem_readData),
    .fault_clear    (fault_clear),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .rd_cnt         (rd_cnt),
    .wr_cnt         (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        v;
    logic        rd;
    logic        wr;
    logic [1:0]  mask;
    logic        sext;
    logic [31:0] wdata;
    logic        clr;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic [31:0] exp_faddr;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] addr, logic v, logic rd, logic wr,
                              logic [1:0] mask, logic sext, logic [31:0] wdata,
                              logic clr, logic [31:0] erd, logic ef,
                              logic [31:0] efa, logic [15:0] ercnt, logic [15:0] ewcnt);
    vec_t t;
    t.addr = addr; t.v = v; t.rd = rd; t.wr = wr; t.mask = mask; t.sext = sext;
    t.wdata = wdata; t.clr = clr; t.exp_rdata = erd; t.exp_fault = ef;
    t.exp_faddr = efa; t.exp_rd = ercnt; t.exp_wr = ewcnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic v, input logic rd,
                       input logic wr, input logic [1:0] mask, input logic sext,
                       input logic [31:0] wdata, input logic clr);
    dmem_addr = addr; dmem_valid = v; dmem_memRead = rd; dmem_memWrite = wr;
    dmem_maskMode = mask; dmem_sext = sext; dmem_writeData = wdata; fault_clear = clr;
  endtask

  task automatic check_status(input string tag, input logic ef, input logic [31:0] efa,
                              input logic [15:0] er, input logic [15:0] ew);
    chk({tag, "_fault"},      {31'h0, fault}, {31'h0, ef});
    chk({tag, "_fault_addr"}, fault_addr, efa);
    chk({tag, "_rd_cnt"},     {16'h0, rd_cnt}, {16'h0, er});
    chk({tag, "_wr_cnt"},     {16'h0, wr_cnt}, {16'h0, ew});
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t.addr, t.v, t.rd, t.wr, t.mask, t.sext, t.wdata, t.clr);
    #1;
    chk($sformatf("v%0d_rdata", idx), dmem_readData, t.exp_rdata);
    @(posedge clk);
    #1;
    check_status($sformatf("v%0d", idx), t.exp_fault, t.exp_faddr, t.exp_rd, t.exp_wr);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);

    //              addr        v  rd wr mask s wdata         clr rdata         f  faddr       rd  wr
    vecs.push_back(mk(32'h10,   1, 0, 1, 2, 0, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,     0,  1));
    vecs.push_back(mk(32'h10,   1, 1, 0, 2, 0, 32'h0,        0, 32'hDEADBEEF, 0, 32'h0,     1,  1));
    vecs.push_back(mk(32'h13,   1, 1, 0, 0, 1, 32'h0,        0, 32'hFFFFFFDE, 0, 32'h0,     2,  1));
    vecs.push_back(mk(32'h20,   1, 0, 1, 2, 0, 32'h11223344, 0, 32'h0,        0, 32'h0,     2,  2));
    vecs.push_back(mk(32'h21,   1, 0, 1, 0, 0, 32'h000000AA, 0, 32'h0,        0, 32'h0,     2,  3));
    vecs.push_back(mk(32'h20,   1, 1, 0, 2, 0, 32'h0,        0, 32'h1122AA44, 0, 32'h0,     3,  3));
    vecs.push_back(mk(32'h22,   1, 1, 0, 1, 0, 32'h0,        0, 32'h00001122, 0, 32'h0,     4,  3));
    vecs.push_back(mk(32'h21,   1, 1, 0, 0, 1, 32'h0,        0, 32'hFFFFFFAA, 0, 32'h0,     5,  3));
    vecs.push_back(mk(32'h20,   1, 1, 0, 1, 1, 32'h0,        0, 32'hFFFFAA44, 0, 32'h0,     6,  3));
    vecs.push_back(mk(32'h23,   1, 1, 0, 0, 0, 32'h0,        0, 32'h00000011, 0, 32'h0,     7,  3));
    vecs.push_back(mk(32'h30,   1, 0, 1, 2, 0, 32'h55667788, 0, 32'h0,        0, 32'h0,     7,  4));
    vecs.push_back(mk(32'h31,   1, 0, 1, 1, 0, 32'h0000BEEF, 0, 32'h0,        1, 32'h31,    7,  4));
    vecs.push_back(mk(32'h30,   1, 1, 0, 2, 0, 32'h0,        0, 32'h55667788, 1, 32'h31,    8,  4));
    vecs.push_back(mk(32'h40,   1, 1, 0, 3, 0, 32'h0,        0, 32'h0,        1, 32'h31,    8,  4));
    vecs.push_back(mk(32'h45,   1, 1, 0, 2, 0, 32'h0,        1, 32'h0,        1, 32'h45,    8,  4));
    vecs.push_back(mk(32'h0,    0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h45,    8,  4));
    vecs.push_back(mk(32'h1000, 1, 1, 0, 2, 0, 32'h0,        0, 32'h0,        1, 32'h1000,  8,  4));
    vecs.push_back(mk(32'h0,    0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h1000,  8,  4));
    vecs.push_back(mk(32'h50,   1, 1, 0, 3, 0, 32'h0,        0, 32'h0,        1, 32'h50,    8,  4));
    vecs.push_back(mk(32'h0,    0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h50,    8,  4));
    vecs.push_back(mk(32'h50,   1, 0, 1, 2, 0, 32'h1,        0, 32'h0,        0, 32'h50,    8,  5));
    vecs.push_back(mk(32'h50,   1, 1, 1, 2, 0, 32'h2,        0, 32'h1,        0, 32'h50,    9,  6));
    vecs.push_back(mk(32'h50,   1, 1, 0, 2, 0, 32'h0,        0, 32'h2,        0, 32'h50,   10,  6));
    vecs.push_back(mk(32'h50,   0, 1, 1, 2, 0, 32'h77,       0, 32'h0,        0, 32'h50,   10,  6));
    vecs.push_back(mk(32'h50,   1, 0, 0, 2, 0, 32'h77,       0, 32'h0,        0, 32'h50,   10,  6));
    vecs.push_back(mk(32'h50,   1, 1, 0, 2, 0, 32'h0,        0, 32'h2,        0, 32'h50,   11,  6));
    vecs.push_back(mk(32'h20,   1, 1, 0, 2, 0, 32'h0,        0, 32'h1122AA44, 0, 32'h50,   12,  6));
    vecs.push_back(mk(32'h20,   1, 0, 1, 2, 0, 32'h1122AA99, 0, 32'h0,        0, 32'h50,   12,  7));
    vecs.push_back(mk(32'h20,   1, 1, 0, 2, 0, 32'h0,        0, 32'h1122AA99, 0, 32'h50,   13,  7));
    vecs.push_back(mk(32'h22,   1, 0, 1, 1, 0, 32'h00001234, 0, 32'h0,        0, 32'h50,   13,  8));
    vecs.push_back(mk(32'h20,   1, 1, 0, 2, 0, 32'h0,        0, 32'h1234AA99, 0, 32'h50,   14,  8));
    vecs.push_back(mk(32'h1010, 1, 0, 1, 2, 0, 32'h12345678, 0, 32'h0,        1, 32'h1010, 14,  8));
    vecs.push_back(mk(32'h10,   1, 1, 0, 2, 0, 32'h0,        0, 32'hDEADBEEF, 1, 32'h1010, 15,  8));
    vecs.push_back(mk(32'h0,    0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h1010, 15,  8));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_status("reset", 1'b0, 32'h0, 16'h0, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Counter saturation: run reads of 0x50 back to back until the top.
    @(negedge clk);
    drive(32'h50, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    repeat (16'hFFFE - 15) @(posedge clk);
    #1;
    chk("sat_fffe", {16'h0, rd_cnt}, 32'h0000FFFE);
    @(posedge clk);
    #1;
    chk("sat_ffff", {16'h0, rd_cnt}, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", {16'h0, rd_cnt}, 32'h0000FFFF);
    chk("sat_wr", {16'h0, wr_cnt}, 32'h8);

    // Raise a fault, then reset while a good write and read are presented.
    @(negedge clk);
    drive(32'h61, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_status("prerst", 1'b1, 32'h61, 16'hFFFF, 16'h8);

    @(negedge clk);
    reset = 1'b1;
    drive(32'h50, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h99, 1'b0);
    #1;
    chk("rst_rdata_comb", dmem_readData, 32'h2);
    @(posedge clk);
    #1;
    check_status("rst1", 1'b0, 32'h0, 16'h0, 16'h0);

    @(negedge clk);
    drive(32'h63, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check_status("rst2", 1'b0, 32'h0, 16'h0, 16'h0);

    @(negedge clk);
    reset = 1'b0;
    drive(32'h50, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    #1;
    chk("post_rst_retained", dmem_readData, 32'h2);
    @(posedge clk);
    #1;
    check_status("post_rst", 1'b0, 32'h0, 16'h1, 16'h0);

    @(negedge clk);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-index width (2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0, word aligned.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- dmem_addr  in  32  byte address.
- dmem_valid  in  1  request valid.
- dmem_memRead  in  1  read request.
- dmem_memWrite  in  1  write request.
- dmem_maskMode  in  2  0 byte, 1 half, 2 word, 3 reserved.
- dmem_sext  in  1  sign-extend loads.
- dmem_writeData  in  32  store data, right-aligned.
- dmem_readData  out  32  load data, right-aligned.
- fault_clear  in  1  clears the sticky fault.
- fault  out  1  sticky access fault.
- fault_addr  out  32  address of the first fault.
- rd_cnt  out  16  saturating count of accepted reads.
- wr_cnt  out  16  saturating count of accepted writes.

Function
REQ-005 SHALL define an access as active when dmem_valid is 1 and (dmem_memRead or dmem_memWrite) is 1; all other cycles are idle and SHALL have no side effects.
REQ-006 SHALL define the offset as dmem_addr - BASE_ADDR, the word index as offset[ADDR_WIDTH+1:2], and the lane as offset[1:0].
REQ-007 SHALL flag an access as bad when any of these holds:
- offset >= 4*2^ADDR_WIDTH;
- maskMode is 3;
- half access with lane[0] = 1;
- word access with lane != 0.
REQ-008 SHALL drive dmem_readData combinationally, in the same cycle, from the pre-clock-edge array contents.
REQ-009 For a good active read, dmem_readData SHALL be:
- byte: lane byte, sign-extended from bit 7 if dmem_sext, else zero-extended;
- half: lanes {lane[1],1}:{lane[1],0}, sign-extended from bit 15 if dmem_sext, else zero-extended;
- word: the full word.
REQ-010 SHALL drive dmem_readData to 32'h0 when there is no active read or the access is bad.
REQ-011 A good active write SHALL update the array at the rising clk edge, touching only the addressed lanes:
- byte: writeData[7:0] into the lane;
- half: writeData[15:0] into lanes lane[1]*2 and lane[1]*2+1;
- word: all four lanes.
REQ-012 A bad access SHALL NOT modify the array.
REQ-013 When memRead and memWrite are both set, SHALL return pre-write data and commit the write at the edge.
REQ-014 SHALL make write data visible to reads from the cycle after the write edge (no write-through bypass).
REQ-015 SHALL update fault at each edge as follows:
- a bad active access sets fault to 1;
- fault_addr captures dmem_addr only when fault was 0 before the edge;
- fault_clear with no bad access clears fault to 0 and leaves fault_addr unchanged;
- fault_clear together with a bad access leaves fault at 1 and loads fault_addr with the new address.
REQ-016 rd_cnt SHALL increment on each good active read, and wr_cnt on each good active write, each saturating at 16'hFFFF.
REQ-017 A simultaneous read and write SHALL increment both counters.
REQ-018 SHALL accept back-to-back accesses every cycle, with no stall and no ready signal.
REQ-019 SHALL serve a sub-word store sent as a read of the whole word followed by a word write as two independent, correct accesses.

Reset
REQ-020 On reset, SHALL set fault=0, fault_addr=32'h0, rd_cnt=0, wr_cnt=0.
REQ-021 SHALL NOT reset the array contents, and SHALL ignore writes during a reset cycle.
REQ-022 dmem_readData SHALL remain combinational during reset.
REQ-023 A reset asserted mid-sequence SHALL take priority over fault_clear, counter updates and fault capture in that cycle.

Structure
REQ-024 Package dmem_pkg SHALL hold the MASK_B=2'd0, MASK_H=2'd1, MASK_W=2'd2 and MASK_RSV=2'd3 constants.
REQ-025 Package dmem_pkg SHALL also hold the COUNT_WIDTH=16 constant.
REQ-026 SHALL instantiate one combinational sub-module, dmem_load_fmt, which performs lane select and extension (word, lane, maskMode, sext -> readData).
REQ-027 The array, the bad-access check, the fault logic and the counters SHALL live in dmem_resp.

Verification
REQ-028 Word write then read: write 32'hDEADBEEF to addr 0x10 with mask 2. In the next cycle, a read of 0x10 returns 32'hDEADBEEF and a read of 0x13 with mask 0 and sext=1 returns 32'hFFFFFFDE. Expected rd_cnt=2 and wr_cnt=1.
REQ-029 Byte and half lanes:
- with word 0x20 = 32'h11223344, a byte write of 8'hAA at 0x21 makes the word read 32'h1122AA44;
- a half read at 0x22 with sext=0 then returns 32'h00001122.
REQ-030 Misaligned half write at 0x31: the word at 0x30 is unchanged and fault=1 with fault_addr=0x31. A later bad access at 0x40 leaves fault_addr at 0x31. fault_clear together with a bad access at 0x45 gives fault=1 and fault_addr=0x45.
REQ-031 Out-of-range and reserved mode, with ADDR_WIDTH=10: a read at 0x1000 and a read with mask 3 each return 32'h0, set fault, and leave rd_cnt unchanged.
REQ-032 Simultaneous read and write of 0x50, where the old value is 32'h1 and the write data is 32'h2: readData is 32'h1 in that cycle and 32'h2 in the next.
REQ-033 Counter saturation and reset:
- preload about 65535 reads and issue 3 more: rd_cnt holds 16'hFFFF;
- assert reset with fault_clear=0: all status outputs read 0 and the array data is retained.
